// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel switch debouncer with per-channel edge ticks
// Ports:
//   clk        - single clock, all state updates on rising edge
//   reset_n    - asynchronous active-low reset
//   sw         - raw asynchronous switch inputs, one bit per channel
//   db_level   - registered debounced level per channel
//   fall_tick  - one-cycle pulse per debounced 1->0 transition
//   rise_tick  - one-cycle pulse per debounced 0->1 transition
//   any_tick   - registered OR of all fall_tick and rise_tick bits
module debounce_multi #(
    parameter int   CHANNELS    = 4,
    parameter int   N           = 21,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] sw,
    output logic [CHANNELS-1:0] db_level,
    output logic [CHANNELS-1:0] fall_tick,
    output logic [CHANNELS-1:0] rise_tick,
    output logic                any_tick
);
    typedef enum logic [1:0] {HIGH = 2'd0, WAIT0 = 2'd1, LOW = 2'd2, WAIT1 = 2'd3} state_t;
    localparam state_t        IDLE_STATE = IDLE_LEVEL ? HIGH : LOW;
    localparam logic [N-1:0]  CNT_LOAD   = '1;
    localparam logic [N-1:0]  CNT_ONE    = {{(N-1){1'b0}}, 1'b1};
    logic [CHANNELS-1:0] w_fall_nxt;
    logic [CHANNELS-1:0] w_rise_nxt;
    logic                r_any;
    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_sw_s;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [N-1:0]           r_cnt;
        logic [N-1:0]           w_cnt_nxt;
        logic                   w_lvl;
        logic                   r_db;
        logic                   r_fall;
        logic                   r_rise;
        assign w_sw_s = r_sync[SYNC_STAGES-1];
        // Level implied by the FSM state; the registered output trails it by one edge
        assign w_lvl  = (r_state == HIGH) || (r_state == WAIT0);
        assign w_fall_nxt[g] = r_db & ~w_lvl;
        assign w_rise_nxt[g] = ~r_db & w_lvl;
        assign db_level[g]  = r_db;
        assign fall_tick[g] = r_fall;
        assign rise_tick[g] = r_rise;
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                HIGH:
                    if (!w_sw_s) begin
                        w_state_nxt = WAIT0;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                WAIT0:
                    if (w_sw_s) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt > CNT_ONE) begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end else begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = '0;
                    end
                LOW:
                    if (w_sw_s) begin
                        w_state_nxt = WAIT1;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                WAIT1:
                    if (!w_sw_s) begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt > CNT_ONE) begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end else begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = '0;
                    end
                default: begin
                    w_state_nxt = IDLE_STATE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync  <= {SYNC_STAGES{IDLE_LEVEL}};
                r_state <= IDLE_STATE;
                r_cnt   <= '0;
                r_db    <= IDLE_LEVEL;
                r_fall  <= 1'b0;
                r_rise  <= 1'b0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], sw[g]};
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_db    <= w_lvl;
                r_fall  <= w_fall_nxt[g];
                r_rise  <= w_rise_nxt[g];
            end
        end
    end
    // Built from the same next-tick terms so it lands on the same edge as the ticks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_any <= 1'b0;
        else          r_any <= |(w_fall_nxt | w_rise_nxt);
    end
    assign any_tick = r_any;
endmodule
